// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - shared encodings for the polynomial-arithmetic datapath.
package dilithium_pkg;

   localparam int DILITHIUM_N = 256;
   localparam int LANES       = 4;

   typedef enum logic [2:0] {
      MODE_FWD_NTT = 3'd0,
      MODE_INV_NTT = 3'd1,
      MODE_MULT    = 3'd2,
      MODE_ADD     = 3'd3,
      MODE_SUB     = 3'd4
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_e;

   function automatic logic is_ntt_mode(input mode_e m);
      return (m == MODE_FWD_NTT) || (m == MODE_INV_NTT);
   endfunction

endpackage

// File: rtl/ntt_beat_counter.sv
// rtl/ntt_beat_counter.sv - beat index, layer-pair index and pipeline drain counter.
module ntt_beat_counter
   import dilithium_pkg::*;
#(
   parameter int PIPE_DEPTH = 8,
   parameter int N_BEATS    = DILITHIUM_N / LANES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       step,
   input  logic       load_drain,
   input  logic       next_pass,
   output logic [5:0] k,
   output logic [3:0] s,
   output logic       last_beat,
   output logic       drain_zero
);

   logic [5:0] k_q, k_d;
   logic [3:0] s_q, s_d;
   logic [4:0] drain_q, drain_d;

   assign last_beat  = (k_q == 6'(N_BEATS - 1));
   assign drain_zero = (drain_q == 5'd0);
   assign k          = k_q;
   assign s          = s_q;

   always_comb begin
      k_d     = k_q;
      s_d     = s_q;
      drain_d = drain_q;
      if (!drain_zero) drain_d = drain_q - 5'd1;
      if (clear) begin
         k_d = 6'd0;
         s_d = 4'd0;
      end else begin
         if (step)      k_d = last_beat ? 6'd0 : k_q + 6'd1;
         if (next_pass) s_d = s_q + 4'd2;
      end
      // Loaded on the last beat so DRAIN lasts exactly PIPE_DEPTH cycles.
      if (load_drain) drain_d = 5'(PIPE_DEPTH - 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q     <= 6'd0;
         s_q     <= 4'd0;
         drain_q <= 5'd0;
      end else begin
         k_q     <= k_d;
         s_q     <= s_d;
         drain_q <= drain_d;
      end
   end

endmodule

// File: rtl/ntt_pass_sequencer.sv
// rtl/ntt_pass_sequencer.sv - pass/beat sequencing FSM for one polynomial operation.
module ntt_pass_sequencer
   import dilithium_pkg::*;
#(
   parameter int PIPE_DEPTH = 8,
   parameter int N_BEATS    = DILITHIUM_N / LANES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] mode_in,
   input  logic       dp_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       tw_rst,
   output logic       tw_en,
   output logic [2:0] tw_mode,
   output logic [5:0] k,
   output logic [3:0] s,
   output logic       issue,
   output logic       pass_last
);

   seq_state_e state_q, state_d;
   mode_e      mode_q, mode_d;
   logic       err_q, err_d;
   logic       clear, step, load_drain, next_pass;
   logic       last_beat, drain_zero;

   ntt_beat_counter #(
      .PIPE_DEPTH(PIPE_DEPTH),
      .N_BEATS   (N_BEATS)
   ) u_beat_counter (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .step      (step),
      .load_drain(load_drain),
      .next_pass (next_pass),
      .k         (k),
      .s         (s),
      .last_beat (last_beat),
      .drain_zero(drain_zero)
   );

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      err_d      = 1'b0;
      clear      = 1'b0;
      step       = 1'b0;
      load_drain = 1'b0;
      next_pass  = 1'b0;
      tw_rst     = 1'b0;
      tw_en      = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (mode_in <= 3'd4) begin
                  mode_d  = mode_e'(mode_in);
                  clear   = 1'b1;
                  state_d = ST_PREP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_PREP: begin
            tw_rst  = 1'b1;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            tw_en = dp_ready;
            if (dp_ready) begin
               step = 1'b1;
               if (last_beat) begin
                  load_drain = 1'b1;
                  state_d    = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_zero) begin
               if (is_ntt_mode(mode_q) && (s < 4'd6)) begin
                  next_pass = 1'b1;
                  state_d   = ST_PREP;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign issue     = tw_en;
   assign err       = err_q;
   assign tw_mode   = mode_q;
   assign pass_last = busy && (!is_ntt_mode(mode_q) || (s == 4'd6));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_FWD_NTT;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// tb/tb_ntt_pass_sequencer.sv - self-checking bench for ntt_pass_sequencer.
module tb_ntt_pass_sequencer;

   localparam int PIPE    = 8;
   localparam int N_BEATS = 64;
   localparam int MAXC    = 1200;

   logic       clk = 1'b0;
   logic       rst, start, dp_ready;
   logic [2:0] mode_in, tw_mode;
   logic       busy, done, err, tw_rst, tw_en, issue, pass_last;
   logic [5:0] k;
   logic [3:0] s;

   int checks = 0;
   int errors = 0;

   bit rdy    [MAXC];
   bit e_busy [MAXC];
   bit e_done [MAXC];
   bit e_rst  [MAXC];
   bit e_iss  [MAXC];
   bit e_pl   [MAXC];
   int e_k    [MAXC];
   int e_s    [MAXC];
   int e_end;

   always #5 clk = ~clk;

   ntt_pass_sequencer #(.PIPE_DEPTH(PIPE), .N_BEATS(N_BEATS)) dut (
      .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .dp_ready(dp_ready),
      .busy(busy), .done(done), .err(err), .tw_rst(tw_rst), .tw_en(tw_en),
      .tw_mode(tw_mode), .k(k), .s(s), .issue(issue), .pass_last(pass_last)
   );

   // Expected per-cycle trace: cycle 0 carries start, then per pass one
   // preload cycle, 64 accepted beats (stalls where rdy is low), PIPE drain cycles.
   task automatic build_model(input int mode);
      int c, sv, beats, npass;
      for (int i = 0; i < MAXC; i++) begin
         e_busy[i] = 0; e_done[i] = 0; e_rst[i] = 0; e_iss[i] = 0;
         e_pl[i] = 0; e_k[i] = 0; e_s[i] = 0;
      end
      npass = (mode <= 1) ? 4 : 1;
      c = 1;
      sv = 0;
      for (int p = 0; p < npass; p++) begin
         sv = 2 * p;
         e_busy[c] = 1; e_rst[c] = 1; e_s[c] = sv; c++;
         beats = 0;
         while (beats < N_BEATS && c < MAXC - PIPE - 4) begin
            e_busy[c] = 1; e_iss[c] = rdy[c]; e_k[c] = beats; e_s[c] = sv;
            if (rdy[c]) beats++;
            c++;
         end
         for (int d = 0; d < PIPE; d++) begin
            e_busy[c] = 1; e_s[c] = sv; c++;
         end
      end
      e_busy[c] = 1; e_done[c] = 1; e_s[c] = sv;
      e_end = c;
      for (int i = 0; i < MAXC; i++)
         e_pl[i] = e_busy[i] && (mode > 1 || e_s[i] == 6);
   endtask

   task automatic run_op(input string name, input int mode, input int rc,
                         input logic [2:0] rmode, input int exp_done);
      int done_at, n_iss, want;
      logic [6:0] obs, expv;
      build_model(mode);
      want = (exp_done > 0) ? exp_done : e_end;
      done_at = -1;
      n_iss = 0;
      start = 1'b1; mode_in = 3'(mode); dp_ready = rdy[0];
      for (int c = 1; c <= e_end + 1; c++) begin
         @(negedge clk);
         start = (c == rc);
         if (c == rc) mode_in = rmode;
         dp_ready = rdy[c];
         #1;
         obs  = {busy, done, err, tw_rst, tw_en, issue, pass_last};
         expv = {e_busy[c], e_done[c], 1'b0, e_rst[c], e_iss[c], e_iss[c], e_pl[c]};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s ctrl(busy,done,err,tw_rst,tw_en,issue,pass_last) cycle %0d got %b want %b",
                     name, c, obs, expv);
         end
         if (e_busy[c]) begin
            checks++;
            if ({k, s, tw_mode} !== {6'(e_k[c]), 4'(e_s[c]), 3'(mode)}) begin
               errors++;
               $display("FAIL %s k/s/tw_mode cycle %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                        name, c, k, s, tw_mode, e_k[c], e_s[c], mode);
            end
         end
         if (done === 1'b1 && done_at < 0) done_at = c;
         if (issue === 1'b1) n_iss++;
      end
      checks++;
      if (done_at !== want) begin
         errors++;
         $display("FAIL %s done_cycle got %0d want %0d", name, done_at, want);
      end
      checks++;
      if (n_iss !== N_BEATS * ((mode <= 1) ? 4 : 1)) begin
         errors++;
         $display("FAIL %s issue_count got %0d want %0d", name, n_iss,
                  N_BEATS * ((mode <= 1) ? 4 : 1));
      end
   endtask

   task automatic check_idle_zero(input string name);
      checks++;
      if ({busy, done, err, tw_rst, tw_en, issue, pass_last, k, s, tw_mode} !== 20'd0) begin
         errors++;
         $display("FAIL %s idle_outputs got %b%b%b%b%b%b%b k=%0d s=%0d mode=%0d want all 0",
                  name, busy, done, err, tw_rst, tw_en, issue, pass_last, k, s, tw_mode);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode_in = 3'd0; dp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_idle_zero("reset_held");
      rst = 1'b0;
      @(negedge clk); #1;
      check_idle_zero("reset_released");
   endtask

   task automatic test_fwd_ntt();
      for (int i = 0; i < MAXC; i++) rdy[i] = 1;
      run_op("fwd_ntt", 0, 0, 3'd0, 293);
   endtask

   task automatic test_inv_ntt_toggle();
      for (int i = 0; i < MAXC; i++) rdy[i] = (i % 2 == 0);
      run_op("inv_toggle", 1, 0, 3'd0, 545);
   endtask

   task automatic test_mult();
      for (int i = 0; i < MAXC; i++) rdy[i] = 1;
      run_op("mult", 2, 0, 3'd0, 74);
   endtask

   task automatic test_random_pointwise();
      int m;
      for (int t = 0; t < 3; t++) begin
         m = 2 + int'($urandom % 3);
         for (int i = 0; i < MAXC; i++) rdy[i] = (($urandom % 4) != 0);
         run_op("pw_random", m, 0, 3'd0, 0);
      end
   endtask

   task automatic test_err();
      logic [2:0] m;
      logic [4:0] obs, expv;
      m = 3'(5 + ($urandom % 3));
      start = 1'b1; mode_in = m; dp_ready = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         obs  = {busy, err, tw_rst, tw_en, done};
         expv = {1'b0, (c == 1), 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL err_mode%0d (busy,err,tw_rst,tw_en,done) cycle %0d got %b want %b",
                     m, c, obs, expv);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      bit hit;
      for (int i = 0; i < MAXC; i++) rdy[i] = 1;
      build_model(0);
      hit = 0;
      start = 1'b1; mode_in = 3'd0; dp_ready = 1'b1;
      for (int c = 1; c <= e_end && !hit; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (e_s[c] == 4 && e_k[c] == 30 && e_iss[c]) begin
            rst = 1'b1;
            hit = 1;
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL reset_mid_op trigger got not_reached want reached");
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_idle_zero("reset_mid_op");
      @(negedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_op no_done got busy=%b done=%b want 0 0", busy, done);
      end
      run_op("fwd_after_rst", 0, 0, 3'd0, 293);
   endtask

   task automatic test_start_during_drain();
      for (int i = 0; i < MAXC; i++) rdy[i] = 1;
      run_op("restart_invalid", 0, 140, 3'd7, 293);
      run_op("restart_valid", 0, 143, 3'd2, 293);
   endtask

   initial begin
      test_reset();
      test_fwd_ntt();
      test_inv_ntt_toggle();
      test_mult();
      test_err();
      test_random_pointwise();
      test_reset_mid_op();
      test_start_during_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
